axi4_burst_mem_slave: RTL and testbench

- Synthesizable-style AXI4 slave that backs a parametrised word memory and is used as the memory-side endpoint in block testbenches.
- Accepts full AXI4 bursts (FIXED/INCR/WRAP, narrow sizes, byte strobes) on independent read and write paths, with one outstanding transaction per direction.
- Returns OKAY/SLVERR responses per the rules below.
- Replaces hand-driven slave tasks with a cycle-accurate, back-to-back-capable responder.

---
 rtl/axi4_pkg.sv | 73 +++++++
 rtl/axi4_addr_gen.sv | 44 ++++
 rtl/axi4_burst_mem_slave.sv | 206 ++++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 types and burst address helpers.
// Used by the burst memory slave and its address generators.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // Bit k set means LEN=k is a legal WRAP length (1, 3, 7, 15).
  localparam logic [15:0] WRAP_LENS = 16'h808A;

  function automatic logic wrap_ok(input logic [7:0] len);
    return (len[7:4] == 4'd0) && WRAP_LENS[len[3:0]];
  endfunction

  function automatic logic illegal(
    input logic [2:0] size,
    input logic [7:0] len,
    input logic [1:0] burst,
    input int         lgn
  );
    return (burst == 2'b11) || (int'(size) > lgn) ||
           ((burst == WRAP) && !wrap_ok(len));
  endfunction

  function automatic logic [31:0] next_addr(
    input logic [31:0] addr,
    input logic [2:0]  size,
    input logic [7:0]  len,
    input logic [1:0]  burst
  );
    logic [31:0] step, algn, wlen, lo;
    step = 32'd1 << size;
    algn = (addr & ~(step - 32'd1)) + step;
    wlen = step * (32'(len) + 32'd1);
    lo   = addr & ~(wlen - 32'd1);
    if (burst == FIXED)
      return addr;
    else if (burst == WRAP && wrap_ok(len))
      return lo | (algn & (wlen - 32'd1));
    else
      return algn;
  endfunction

  function automatic logic in_rng(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [32:0] lim
  );
    return (addr >= base) && ({1'b0, addr - base} < lim);
  endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// Per-direction burst address stepper.
// Holds the burst shape and walks addresses on each advance.
import axi4_pkg::*;

module axi4_addr_gen #(
  parameter logic [31:0] BASE  = 32'h0,
  parameter logic [32:0] LIMIT = 33'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] start,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  input  logic        adv,
  output logic [31:0] addr,
  output logic        in_range
);

  logic [2:0] sz;
  logic [7:0] ln;
  logic [1:0] bu;

  // Capture burst shape on load, step the address on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      sz   <= '0;
      ln   <= '0;
      bu   <= '0;
    end else if (load) begin
      addr <= start;
      sz   <= size;
      ln   <= len;
      bu   <= burst;
    end else if (adv) begin
      addr <= next_addr(addr, sz, ln, bu);
    end
  end

  assign in_range = in_rng(addr, BASE, LIMIT);

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave with independent read/write paths.
// One outstanding burst per direction, registered R channel.
import axi4_pkg::*;

module axi4_burst_mem_slave #(
  parameter int          N     = 4,
  parameter int          I     = 4,
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic [I-1:0]   AWID,
  input  logic [31:0]    AWADDR,
  input  logic [7:0]     AWLEN,
  input  logic [2:0]     AWSIZE,
  input  logic [1:0]     AWBURST,
  input  logic           AWVALID,
  output logic           AWREADY,
  input  logic [8*N-1:0] WDATA,
  input  logic [N-1:0]   WSTRB,
  input  logic           WLAST,
  input  logic           WVALID,
  output logic           WREADY,
  output logic [I-1:0]   BID,
  output logic [1:0]     BRESP,
  output logic           BVALID,
  input  logic           BREADY,
  input  logic [I-1:0]   ARID,
  input  logic [31:0]    ARADDR,
  input  logic [7:0]     ARLEN,
  input  logic [2:0]     ARSIZE,
  input  logic [1:0]     ARBURST,
  input  logic           ARVALID,
  output logic           ARREADY,
  output logic [I-1:0]   RID,
  output logic [8*N-1:0] RDATA,
  output logic [1:0]     RRESP,
  output logic           RLAST,
  output logic           RVALID,
  input  logic           RREADY
);

  localparam int LGN = $clog2(N);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'(N);

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a - BASE) >> LGN);
  endfunction

  logic [8*N-1:0] mem [DEPTH];

  wstate_t ws, ws_nxt;
  rstate_t rs, rs_nxt;

  logic        aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [7:0]  wcnt, rcnt;
  logic        w_err, w_ill, r_ill;
  logic [31:0] w_addr, r_addr, r_la, r_start;
  logic        w_inr, r_inr, r_ok, r_launch;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign b_fire  = BVALID && BREADY;
  assign ar_fire = ARVALID && ARREADY;
  assign r_fire  = RVALID && RREADY;

  // Read gen always holds the address of the next beat to launch.
  assign r_start  = next_addr(ARADDR, ARSIZE, ARLEN, ARBURST);
  assign r_launch = ar_fire || (r_fire && !RLAST);
  assign r_la     = ar_fire ? ARADDR : r_addr;
  assign r_ok     = ar_fire
    ? (!illegal(ARSIZE, ARLEN, ARBURST, LGN) &&
       in_rng(ARADDR, BASE, LIMIT))
    : (!r_ill && r_inr);

  axi4_addr_gen #(.BASE(BASE), .LIMIT(LIMIT)) u_wgen (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .load     (aw_fire),
    .start    (AWADDR),
    .size     (AWSIZE),
    .len      (AWLEN),
    .burst    (AWBURST),
    .adv      (w_fire),
    .addr     (w_addr),
    .in_range (w_inr)
  );

  axi4_addr_gen #(.BASE(BASE), .LIMIT(LIMIT)) u_rgen (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .load     (ar_fire),
    .start    (r_start),
    .size     (ARSIZE),
    .len      (ARLEN),
    .burst    (ARBURST),
    .adv      (r_fire && !RLAST),
    .addr     (r_addr),
    .in_range (r_inr)
  );

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) ws <= W_IDLE;
    else          ws <= ws_nxt;
  end

  // Write FSM next state: beat count, not WLAST, ends the burst.
  always_comb begin
    ws_nxt = ws;
    unique case (ws)
      W_IDLE:  if (aw_fire) ws_nxt = W_DATA;
      W_DATA:  if (w_fire && wcnt == 8'd0) ws_nxt = W_RESP;
      W_RESP:  if (b_fire) ws_nxt = W_IDLE;
      default: ws_nxt = W_IDLE;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    AWREADY = (ws == W_IDLE);
    WREADY  = (ws == W_DATA);
    BVALID  = (ws == W_RESP);
    BRESP   = w_err ? SLVERR : OKAY;
  end

  // Write burst bookkeeping and sticky error flag.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wcnt  <= '0;
      w_err <= 1'b0;
      w_ill <= 1'b0;
      BID   <= '0;
    end else if (aw_fire) begin
      BID   <= AWID;
      wcnt  <= AWLEN;
      w_ill <= illegal(AWSIZE, AWLEN, AWBURST, LGN);
      w_err <= illegal(AWSIZE, AWLEN, AWBURST, LGN);
    end else if (w_fire) begin
      wcnt <= wcnt - 8'd1;
      if ((WLAST != (wcnt == 8'd0)) || !w_inr)
        w_err <= 1'b1;
    end
  end

  // Byte-strobed memory write; storage is never reset.
  always_ff @(posedge ACLK) begin
    if (w_fire && w_inr && !w_ill) begin
      for (int k = 0; k < N; k++)
        if (WSTRB[k])
          mem[widx(w_addr)][8*k +: 8] <= WDATA[8*k +: 8];
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rs <= R_IDLE;
    else          rs <= rs_nxt;
  end

  // Read FSM next state.
  always_comb begin
    rs_nxt = rs;
    unique case (rs)
      R_IDLE:  if (ar_fire) rs_nxt = R_DATA;
      R_DATA:  if (r_fire && RLAST) rs_nxt = R_IDLE;
      default: rs_nxt = R_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    ARREADY = (rs == R_IDLE);
    RVALID  = (rs == R_DATA);
  end

  // Registered R beat: launched on AR accept or on each non-final R accept.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      RDATA <= '0;
      RRESP <= OKAY;
      RLAST <= 1'b0;
      RID   <= '0;
      rcnt  <= '0;
      r_ill <= 1'b0;
    end else begin
      if (ar_fire) begin
        RID   <= ARID;
        rcnt  <= ARLEN;
        r_ill <= illegal(ARSIZE, ARLEN, ARBURST, LGN);
      end else if (r_launch) begin
        rcnt <= rcnt - 8'd1;
      end
      if (r_launch) begin
        RDATA <= r_ok ? mem[widx(r_la)] : '0;
        RRESP <= r_ok ? OKAY : SLVERR;
        RLAST <= ar_fire ? (ARLEN == 8'd0) : (rcnt == 8'd1);
      end else if (r_fire) begin
        RLAST <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for the AXI4 burst memory slave.
// Hand-computed vectors with immediate assertion checks.
module tb_axi4_burst_mem_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic        BVALID, BREADY, ARVALID, ARREADY;
  logic        RLAST, RVALID, RREADY;
  logic [3:0]  WSTRB;

  int vecs = 0;
  int errs = 0;

  logic [31:0] wd [16];
  logic [3:0]  wsb [16];
  logic [31:0] er [16];
  logic [1:0]  ep [16];

  axi4_burst_mem_slave #(
    .N(4), .I(4), .DEPTH(1024), .BASE(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id,
                          input int bad_last, input int bdly,
                          input logic [1:0] eresp, input string tag);
    AWADDR = addr; AWLEN = len; AWSIZE = 3'd2;
    AWBURST = burst; AWID = id; AWVALID = 1'b1;
    chk({tag, ".awready"}, AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wd[b]; WSTRB = wsb[b];
      WLAST = (b == int'(len)) ^ (b == bad_last);
      WVALID = 1'b1;
      if (b == 0) chk({tag, ".wready"}, WREADY, 1);
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk({tag, ".bvalid"}, BVALID, 1);
    chk({tag, ".bresp"}, BRESP, eresp);
    chk({tag, ".bid"}, BID, id);
    for (int d = 0; d < bdly; d++) begin
      tick();
      chk({tag, ".bhold_v"}, BVALID, 1);
      chk({tag, ".bhold_r"}, BRESP, eresp);
      chk({tag, ".bhold_id"}, BID, id);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk({tag, ".bdone"}, BVALID, 0);
    chk({tag, ".awready2"}, AWREADY, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id,
                         input bit toggle, input string tag);
    ARADDR = addr; ARLEN = len; ARSIZE = 3'd2;
    ARBURST = burst; ARID = id; ARVALID = 1'b1;
    RREADY = !toggle;
    chk({tag, ".arready"}, ARREADY, 1);
    tick();
    ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (toggle) begin
        RREADY = 1'b0;
        tick();
        chk({tag, ".stall_v"}, RVALID, 1);
        chk({tag, ".stall_d"}, RDATA, er[b]);
        chk({tag, ".stall_l"}, RLAST, (b == int'(len)));
        RREADY = 1'b1;
      end
      chk({tag, ".rvalid"}, RVALID, 1);
      chk({tag, ".rdata"}, RDATA, er[b]);
      chk({tag, ".rresp"}, RRESP, ep[b]);
      chk({tag, ".rlast"}, RLAST, (b == int'(len)));
      chk({tag, ".rid"}, RID, id);
      tick();
    end
    RREADY = 1'b0;
    chk({tag, ".rdone"}, RVALID, 0);
    chk({tag, ".arready2"}, ARREADY, 1);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
    WVALID = 1'b0; BREADY = 1'b0; ARID = '0; ARADDR = '0;
    ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst.awready", AWREADY, 1);
    chk("rst.arready", ARREADY, 1);
    chk("rst.wready", WREADY, 0);
    chk("rst.bvalid", BVALID, 0);
    chk("rst.rvalid", RVALID, 0);
    chk("rst.rlast", RLAST, 0);
    chk("rst.bid", BID, 0);
    chk("rst.rid", RID, 0);
    chk("rst.bresp", BRESP, 0);
    chk("rst.rresp", RRESP, 0);
    chk("rst.rdata", RDATA, 0);
    ARESETn = 1'b1;
    tick();

    // INCR write and readback
    for (int b = 0; b < 4; b++) begin
      wd[b] = 32'hA0 + b; wsb[b] = 4'hF;
      er[b] = 32'hA0 + b; ep[b] = 2'b00;
    end
    do_write(32'h10, 8'd3, 2'b01, 4'd3, -1, 0, 2'b00, "incr_w");
    do_read(32'h10, 8'd3, 2'b01, 4'd6, 1'b0, "incr_r");

    // WRAP read: 0x18, 0x1C, 0x10, 0x14
    er[0] = 32'hA2; er[1] = 32'hA3; er[2] = 32'hA0; er[3] = 32'hA1;
    do_read(32'h18, 8'd3, 2'b10, 4'd7, 1'b0, "wrap_r");

    // Strobes with delayed BREADY
    wd[0] = 32'hDEADBEEF; wsb[0] = 4'hF;
    do_write(32'h40, 8'd0, 2'b01, 4'd1, -1, 0, 2'b00, "strb_w1");
    wd[0] = 32'h11223344; wsb[0] = 4'b0101;
    do_write(32'h40, 8'd0, 2'b01, 4'd2, -1, 5, 2'b00, "strb_w2");
    er[0] = 32'hDE22BE44; ep[0] = 2'b00;
    do_read(32'h40, 8'd0, 2'b01, 4'd2, 1'b0, "strb_r");

    // Write running off the top of memory
    wd[0] = 32'h55667788; wsb[0] = 4'hF;
    wd[1] = 32'h99999999; wsb[1] = 4'hF;
    do_write(32'd4092, 8'd1, 2'b01, 4'd9, -1, 0, 2'b10, "oor_w");
    er[0] = 32'h55667788; ep[0] = 2'b00;
    er[1] = 32'h0;        ep[1] = 2'b10;
    do_read(32'd4092, 8'd1, 2'b01, 4'd9, 1'b0, "oor_r");

    // Reserved burst type
    for (int b = 0; b < 3; b++) begin
      er[b] = 32'h0; ep[b] = 2'b10;
    end
    do_read(32'h10, 8'd2, 2'b11, 4'd4, 1'b0, "rsv_r");

    // Early WLAST flags an error
    wd[0] = 32'h1; wd[1] = 32'h2; wsb[0] = 4'hF; wsb[1] = 4'hF;
    do_write(32'h20, 8'd1, 2'b01, 4'd5, 0, 0, 2'b10, "wlast_w");

    // RREADY toggling backpressure
    for (int b = 0; b < 4; b++) begin
      er[b] = 32'hA0 + b; ep[b] = 2'b00;
    end
    do_read(32'h10, 8'd3, 2'b01, 4'd8, 1'b1, "bp_r");

    // Same-cycle write and read launch on one word
    wd[0] = 32'h12345678; wsb[0] = 4'hF;
    do_write(32'h80, 8'd0, 2'b01, 4'd1, -1, 0, 2'b00, "cc_w0");
    AWADDR = 32'h80; AWLEN = 8'd0; AWSIZE = 3'd2;
    AWBURST = 2'b01; AWID = 4'd2; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h80; ARLEN = 8'd0; ARSIZE = 3'd2;
    ARBURST = 2'b01; ARID = 4'd3; ARVALID = 1'b1; RREADY = 1'b1;
    chk("cc.wready", WREADY, 1);
    tick();
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    chk("cc.rdata_old", RDATA, 32'h12345678);
    chk("cc.rlast", RLAST, 1);
    chk("cc.bvalid", BVALID, 1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    er[0] = 32'hCAFEF00D; ep[0] = 2'b00;
    do_read(32'h80, 8'd0, 2'b01, 4'd3, 1'b0, "cc_new");

    // Reset during beat 2 of a 4-beat write
    AWADDR = 32'h100; AWLEN = 8'd3; AWSIZE = 3'd2;
    AWBURST = 2'b01; AWID = 4'd5; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      WDATA = 32'hC0 + b; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      tick();
    end
    WDATA = 32'hC2;
    #2;
    ARESETn = 1'b0;
    #1;
    chk("mrst.wready", WREADY, 0);
    chk("mrst.bvalid", BVALID, 0);
    WVALID = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
    chk("mrst.awready", AWREADY, 1);
    chk("mrst.arready", ARREADY, 1);
    chk("mrst.bvalid2", BVALID, 0);
    chk("mrst.rvalid", RVALID, 0);
    wd[0] = 32'hD2; wd[1] = 32'hD3; wsb[0] = 4'hF; wsb[1] = 4'hF;
    do_write(32'h108, 8'd1, 2'b01, 4'd6, -1, 0, 2'b00, "mrst_w");
    er[0] = 32'hC0; er[1] = 32'hC1; er[2] = 32'hD2; er[3] = 32'hD3;
    for (int b = 0; b < 4; b++) ep[b] = 2'b00;
    do_read(32'h100, 8'd3, 2'b01, 4'd6, 1'b0, "mrst_r");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
